// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the single
// downstream memory port. The arbiter uses the slave view; whatever drives
// the requests and models the memory uses the master view.
interface mem_port_arbiter_if #(
    parameter int N_PORTS = 3,
    parameter int BW_ADDR = 24
);
    logic [N_PORTS-1:0]         req_i;
    logic [N_PORTS-1:0]         reqBlock_i;
    logic [N_PORTS-1:0]         rw_i;
    logic [N_PORTS-1:0]         clear_i;
    logic [N_PORTS*BW_ADDR-1:0] add_i;
    logic [N_PORTS*32-1:0]      data_i;
    logic [N_PORTS-1:0]         ready_o;
    logic [N_PORTS-1:0]         valid_o;
    logic [N_PORTS-1:0]         done_o;
    logic [31:0]                data_o;
    logic                       mem_req_o;
    logic                       mem_reqBlock_o;
    logic                       mem_rw_o;
    logic                       mem_clear_o;
    logic [BW_ADDR-1:0]         mem_add_o;
    logic [31:0]                mem_data_o;
    logic                       mem_ready_i;
    logic                       mem_valid_i;
    logic                       mem_done_i;
    logic [31:0]                mem_data_i;
    logic [2:0]                 grant_o;
    logic                       busy_o;
    logic                       beat_err_o;
    logic [N_PORTS*32-1:0]      grant_count_o;

    modport slave (
        input  req_i, reqBlock_i, rw_i, clear_i, add_i, data_i,
        input  mem_ready_i, mem_valid_i, mem_done_i, mem_data_i,
        output ready_o, valid_o, done_o, data_o,
        output mem_req_o, mem_reqBlock_o, mem_rw_o, mem_clear_o, mem_add_o, mem_data_o,
        output grant_o, busy_o, beat_err_o, grant_count_o
    );

    modport master (
        output req_i, reqBlock_i, rw_i, clear_i, add_i, data_i,
        output mem_ready_i, mem_valid_i, mem_done_i, mem_data_i,
        input  ready_o, valid_o, done_o, data_o,
        input  mem_req_o, mem_reqBlock_o, mem_rw_o, mem_clear_o, mem_add_o, mem_data_o,
        input  grant_o, busy_o, beat_err_o, grant_count_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-port arbiter in front of the single external memory port. One
// transaction at a time: pick a winner, issue its request downstream, steer
// the beat handshakes to the winner only, then pulse its done and go idle.
module mem_port_arbiter #(
    parameter int N_PORTS     = 3,
    parameter int BW_ADDR     = 24,
    parameter int BLOCK_WORDS = 16,
    parameter int RR_MODE     = 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(BLOCK_WORDS) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           grant_q;
    logic [2:0]           rr_last_q;
    logic                 blk_q, rw_q, clr_q;
    logic [BW_ADDR-1:0]   add_q;
    logic [CW-1:0]        beat_cnt_q;
    logic                 beat_err_q;
    logic [31:0]          grant_cnt_q [N_PORTS];

    logic                 any_req;
    logic                 found;
    logic [2:0]           winner;
    logic [2:0]           cand;
    logic [7:0]           req_pad;
    logic                 win_blk, win_rw, win_clr;
    logic [BW_ADDR-1:0]   win_add;
    logic [31:0]          sel_wdata;
    logic [N_PORTS-1:0]   grant_oh;
    logic                 beat;
    logic [CW-1:0]        beat_cnt_inc;
    logic [CW-1:0]        beat_expect;

    assign grant_oh    = N_PORTS'(1) << grant_q;
    assign beat        = (state_q == XFER) && (rw_q ? bus.mem_ready_i : bus.mem_valid_i);
    assign beat_cnt_inc = (beat && beat_cnt_q != '1) ? beat_cnt_q + CW'(1) : beat_cnt_q;
    assign beat_expect = blk_q ? CW'(BLOCK_WORDS) : CW'(1);

    // Winner search: fixed order from port 0, or rotating from the port after the last grant.
    always_comb begin
        req_pad = 8'(bus.req_i);
        any_req = |bus.req_i;
        found   = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (RR_MODE != 0)
                cand = 3'((int'(rr_last_q) + 1 + i) % N_PORTS);
            else
                cand = 3'(i);
            if (!found && req_pad[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Pick out the winner's request fields and the granted port's write data.
    always_comb begin
        win_blk   = 1'b0;
        win_rw    = 1'b0;
        win_clr   = 1'b0;
        win_add   = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (k == int'(winner)) begin
                win_blk = bus.reqBlock_i[k];
                win_rw  = bus.rw_i[k];
                win_clr = bus.clear_i[k];
                win_add = bus.add_i[k*BW_ADDR +: BW_ADDR];
            end
            if (k == int'(grant_q))
                sel_wdata = bus.data_i[k*32 +: 32];
        end
    end

    // State register.
    always_ff @(posedge clock_i) begin
        if (reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: downstream acceptance, then done, then one dead cycle back in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   if (bus.mem_ready_i) state_d = XFER;
            XFER:    if (bus.mem_done_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the grant and request fields, count beats, flag short or long blocks.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            grant_q    <= '0;
            rr_last_q  <= 3'(N_PORTS - 1);
            blk_q      <= 1'b0;
            rw_q       <= 1'b0;
            clr_q      <= 1'b0;
            add_q      <= '0;
            beat_cnt_q <= '0;
            beat_err_q <= 1'b0;
        end else begin
            if (state_q == IDLE && any_req) begin
                grant_q   <= winner;
                rr_last_q <= winner;
                blk_q     <= win_blk;
                rw_q      <= win_rw;
                clr_q     <= win_clr;
                add_q     <= win_add;
            end
            if (state_q == ISSUE && bus.mem_ready_i)
                beat_cnt_q <= '0;
            if (state_q == XFER) begin
                beat_cnt_q <= beat_cnt_inc;
                if (bus.mem_done_i && beat_cnt_inc != beat_expect)
                    beat_err_q <= 1'b1;
            end
        end
    end

    // Per-port grant statistics, saturating rather than wrapping.
    always_ff @(posedge clock_i) begin
        for (int k = 0; k < N_PORTS; k++) begin
            if (reset_i)
                grant_cnt_q[k] <= '0;
            else if (state_q == IDLE && any_req && k == int'(winner) && grant_cnt_q[k] != '1)
                grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
        end
    end

    // Flatten the counters onto the packed statistics bus.
    always_comb begin
        bus.grant_count_o = '0;
        for (int k = 0; k < N_PORTS; k++)
            bus.grant_count_o[k*32 +: 32] = grant_cnt_q[k];
    end

    // Steer downstream handshakes to the granted port only; everyone else sees zeros.
    always_comb begin
        bus.ready_o    = '0;
        bus.valid_o    = '0;
        bus.done_o     = '0;
        bus.data_o     = '0;
        bus.mem_data_o = '0;
        case (state_q)
            ISSUE: if (bus.mem_ready_i) bus.ready_o = grant_oh;
            XFER: begin
                if (rw_q) begin
                    bus.mem_data_o = sel_wdata;
                    if (bus.mem_ready_i) bus.ready_o = grant_oh;
                end else begin
                    bus.data_o = bus.mem_data_i;
                    if (bus.mem_valid_i) bus.valid_o = grant_oh;
                end
            end
            DONE:    bus.done_o = grant_oh;
            default: ;
        endcase
    end

    // Downstream request fields are only presented while a transaction is open.
    always_comb begin
        bus.mem_req_o      = (state_q == ISSUE);
        bus.mem_reqBlock_o = 1'b0;
        bus.mem_rw_o       = 1'b0;
        bus.mem_clear_o    = 1'b0;
        bus.mem_add_o      = '0;
        if (state_q == ISSUE || state_q == XFER) begin
            bus.mem_reqBlock_o = blk_q;
            bus.mem_rw_o       = rw_q;
            bus.mem_clear_o    = clr_q;
            bus.mem_add_o      = add_q;
        end
        bus.grant_o    = grant_q;
        bus.busy_o     = (state_q != IDLE);
        bus.beat_err_o = beat_err_q;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance
// share identical stimulus, a transaction-level model predicts every output
// each cycle, and a few literal expectations pin the model per scenario.
`timescale 1ns/100ps
module tb_mem_port_arbiter;
    localparam int NP = 3;
    localparam int AW = 24;
    localparam int BW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #12.5 clk = ~clk;

    logic [NP-1:0]    req = '0, blk = '0, rw = '0, clr = '0;
    logic [NP*AW-1:0] add = '0;
    logic [NP*32-1:0] wdata = '0;
    logic             mrdy = 1'b0, mval = 1'b0, mdone = 1'b0;
    logic [31:0]      mrdata = '0;

    logic [NP-1:0]    oReady [2], oValid [2], oDone [2];
    logic [31:0]      oData [2], oMemData [2];
    logic             oMemReq [2], oMemBlk [2], oMemRw [2], oMemClr [2], oBusy [2], oErr [2];
    logic [AW-1:0]    oMemAdd [2];
    logic [2:0]       oGrant [2];
    logic [NP*32-1:0] oGcnt [2];

    // Instance 0 is round-robin, instance 1 fixed priority.
    for (genvar g = 0; g < 2; g++) begin : gDut
        mem_port_arbiter_if #(.N_PORTS(NP), .BW_ADDR(AW)) bus ();
        assign bus.req_i       = req;
        assign bus.reqBlock_i  = blk;
        assign bus.rw_i        = rw;
        assign bus.clear_i     = clr;
        assign bus.add_i       = add;
        assign bus.data_i      = wdata;
        assign bus.mem_ready_i = mrdy;
        assign bus.mem_valid_i = mval;
        assign bus.mem_done_i  = mdone;
        assign bus.mem_data_i  = mrdata;
        mem_port_arbiter #(.N_PORTS(NP), .BW_ADDR(AW), .BLOCK_WORDS(BW), .RR_MODE(g == 0 ? 1 : 0)) dut (
            .clock_i (clk),
            .reset_i (rst),
            .bus     (bus)
        );
        assign oReady[g]   = bus.ready_o;
        assign oValid[g]   = bus.valid_o;
        assign oDone[g]    = bus.done_o;
        assign oData[g]    = bus.data_o;
        assign oMemData[g] = bus.mem_data_o;
        assign oMemReq[g]  = bus.mem_req_o;
        assign oMemBlk[g]  = bus.mem_reqBlock_o;
        assign oMemRw[g]   = bus.mem_rw_o;
        assign oMemClr[g]  = bus.mem_clear_o;
        assign oMemAdd[g]  = bus.mem_add_o;
        assign oGrant[g]   = bus.grant_o;
        assign oBusy[g]    = bus.busy_o;
        assign oErr[g]     = bus.beat_err_o;
        assign oGcnt[g]    = bus.grant_count_o;
    end

    int compared = 0;
    int failed   = 0;
    bit checkEn  = 1'b0;

    task automatic checkOutput(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s dut%0d: got %0h, want %0h", name, k, act, exp);
        end
    endtask

    // Priority order as a list, then the first requester along it wins.
    function automatic int pickWinner(input logic [NP-1:0] r, input int last, input bit rr);
        int order [$];
        for (int i = 1; i <= NP; i++)
            order.push_back(rr ? (last + i) % NP : i - 1);
        foreach (order[j])
            if (((r >> order[j]) & 1) != 0) return order[j];
        return 0;
    endfunction

    // Transaction-level model: phase 0 idle, 1 waiting for accept, 2 moving beats, 3 completing.
    int mPhase [2] = '{0, 0};
    int mGrant [2] = '{0, 0};
    int mLast  [2] = '{NP - 1, NP - 1};
    int mCnt   [2][NP];
    bit mErr   [2] = '{0, 0};
    bit mBlk   [2], mRw [2], mClr [2];
    logic [AW-1:0] mAdd [2];
    int mBeats [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mPhase[k] = 0; mGrant[k] = 0; mLast[k] = NP - 1; mErr[k] = 0;
                mBlk[k] = 0; mRw[k] = 0; mClr[k] = 0; mAdd[k] = '0; mBeats[k] = 0;
                for (int p = 0; p < NP; p++) mCnt[k][p] = 0;
            end else if (mPhase[k] == 0) begin
                if (req != '0) begin
                    int w;
                    w = pickWinner(req, mLast[k], k == 0);
                    mGrant[k] = w; mLast[k] = w; mCnt[k][w]++;
                    mBlk[k] = blk[w]; mRw[k] = rw[w]; mClr[k] = clr[w];
                    mAdd[k] = add[w*AW +: AW];
                    mPhase[k] = 1;
                end
            end else if (mPhase[k] == 1) begin
                if (mrdy) begin mBeats[k] = 0; mPhase[k] = 2; end
            end else if (mPhase[k] == 2) begin
                if (mRw[k] ? mrdy : mval) mBeats[k]++;
                if (mdone) begin
                    if (mBeats[k] != (mBlk[k] ? BW : 1)) mErr[k] = 1;
                    mPhase[k] = 3;
                end
            end else begin
                mPhase[k] = 0;
            end
        end
    end

    // Compare every output of both instances against the model mid-cycle.
    always @(negedge clk) begin
        if (checkEn) begin
            for (int k = 0; k < 2; k++) begin
                logic [NP-1:0] oh, eRdy, eVal, eDone;
                oh = NP'(1) << mGrant[k];
                eRdy = '0; eVal = '0; eDone = '0;
                if (mPhase[k] == 1 && mrdy) eRdy = oh;
                if (mPhase[k] == 2 && mRw[k] && mrdy) eRdy = oh;
                if (mPhase[k] == 2 && !mRw[k] && mval) eVal = oh;
                if (mPhase[k] == 3) eDone = oh;
                checkOutput("busy", k, 64'(oBusy[k]), 64'(mPhase[k] != 0));
                checkOutput("grant", k, 64'(oGrant[k]), 64'(mGrant[k]));
                checkOutput("mem_req", k, 64'(oMemReq[k]), 64'(mPhase[k] == 1));
                checkOutput("ready", k, 64'(oReady[k]), 64'(eRdy));
                checkOutput("valid", k, 64'(oValid[k]), 64'(eVal));
                checkOutput("done", k, 64'(oDone[k]), 64'(eDone));
                checkOutput("beat_err", k, 64'(oErr[k]), 64'(mErr[k]));
                for (int p = 0; p < NP; p++)
                    checkOutput($sformatf("grant_count%0d", p), k, 64'(oGcnt[k][p*32 +: 32]), 64'(mCnt[k][p]));
                if (mPhase[k] == 1) begin
                    checkOutput("mem_add", k, 64'(oMemAdd[k]), 64'(mAdd[k]));
                    checkOutput("mem_fields", k, 64'({oMemBlk[k], oMemRw[k], oMemClr[k]}), 64'({mBlk[k], mRw[k], mClr[k]}));
                end
                if (eVal != '0) checkOutput("data_o", k, 64'(oData[k]), 64'(mrdata));
                if (mPhase[k] == 2 && mRw[k])
                    checkOutput("mem_data", k, 64'(oMemData[k]), 64'(wdata[mGrant[k]*32 +: 32]));
            end
        end
    end

    // Tallies for the literal per-scenario expectations.
    int doneCnt [2][NP];
    int doneOrder [2][$];
    int validCnt0;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++)
                if (oDone[k][p] === 1'b1) begin
                    doneCnt[k][p]++;
                    doneOrder[k].push_back(p);
                end
        if (oValid[0][0] === 1'b1) validCnt0++;
    end

    task automatic clearTallies();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NP; p++) doneCnt[k][p] = 0;
            doneOrder[k].delete();
        end
        validCnt0 = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clearTallies();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitIssue(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(posedge clk); #1;
            if (oMemReq[0]) ok = 1'b1;
        end
        if (!ok) begin
            compared++; failed++;
            $display("[TB] FAIL issue_timeout: got no mem_req_o in 50 cycles, want one");
        end
    endtask

    // Memory side of one transaction: accept, nBeats beats, done with the last beat or after.
    task automatic applyStimulus(input int nBeats, input bit isWrite, input bit doneWithLast);
        bit ok;
        waitIssue(ok);
        if (!ok) return;
        mrdy = 1'b1;
        @(posedge clk); #1;
        mrdy = 1'b0;
        for (int b = 0; b < nBeats; b++) begin
            if (isWrite) mrdy = 1'b1;
            else begin mval = 1'b1; mrdata = 32'hD000_0000 + 32'(b); end
            mdone = doneWithLast && (b == nBeats - 1);
            @(posedge clk); #1;
            mrdy = 1'b0; mval = 1'b0; mdone = 1'b0;
        end
        if (!doneWithLast) begin
            mdone = 1'b1;
            @(posedge clk); #1;
            mdone = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expRr [6];
        int order0;
        expRr = '{0, 1, 2, 0, 1, 2};
        clearTallies();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset_busy", k, 64'(oBusy[k]), 64'd0);
            checkOutput("reset_grant_count", k, 64'(oGcnt[k]), 64'd0);
        end

        // Port 0 block read of 16 beats.
        @(posedge clk); #1;
        blk[0] = 1'b1; add[0 +: AW] = 24'h00_1230; req[0] = 1'b1;
        applyStimulus(16, 1'b0, 1'b1);
        req = '0; blk = '0;
        waitCycles(3);
        checkOutput("t1_valid_beats", 0, 64'(validCnt0), 64'd16);
        checkOutput("t1_done_p0", 0, 64'(doneCnt[0][0]), 64'd1);
        checkOutput("t1_beat_err", 0, 64'(oErr[0]), 64'd0);
        checkOutput("t1_grant_count0", 0, 64'(oGcnt[0][31:0]), 64'd1);

        // Three ports requesting continuously, six single-word reads.
        doReset();
        add = {24'h00_0300, 24'h00_0200, 24'h00_0100};
        req = 3'b111;
        for (int t = 0; t < 6; t++) applyStimulus(1, 1'b0, 1'b1);
        req = '0;
        waitCycles(3);
        checkOutput("t2_rr_txns", 0, 64'(doneOrder[0].size()), 64'd6);
        checkOutput("t2_fp_txns", 1, 64'(doneOrder[1].size()), 64'd6);
        for (int t = 0; t < 6 && t < doneOrder[0].size() && t < doneOrder[1].size(); t++) begin
            checkOutput($sformatf("t2_rr_order%0d", t), 0, 64'(doneOrder[0][t]), 64'(expRr[t]));
            checkOutput($sformatf("t2_fp_order%0d", t), 1, 64'(doneOrder[1][t]), 64'd0);
        end
        for (int p = 0; p < NP; p++) begin
            checkOutput($sformatf("t2_rr_count%0d", p), 0, 64'(oGcnt[0][p*32 +: 32]), 64'd2);
            checkOutput($sformatf("t2_fp_count%0d", p), 1, 64'(oGcnt[1][p*32 +: 32]), (p == 0) ? 64'd6 : 64'd0);
        end

        // Port 2 block write cut short at 15 beats.
        doReset();
        add = '0;
        add[2*AW +: AW] = 24'hAB_CDEF; wdata[2*32 +: 32] = 32'hCAFE_0002;
        blk[2] = 1'b1; rw[2] = 1'b1; clr[2] = 1'b1; req[2] = 1'b1;
        applyStimulus(15, 1'b1, 1'b0);
        req = '0;
        waitCycles(3);
        for (int k = 0; k < 2; k++) begin
            checkOutput("t4_done_p2", k, 64'(doneCnt[k][2]), 64'd1);
            checkOutput("t4_beat_err", k, 64'(oErr[k]), 64'd1);
        end
        blk = '0; rw = '0; clr = '0;
        req[0] = 1'b1;
        applyStimulus(1, 1'b0, 1'b1);
        req = '0;
        waitCycles(3);
        checkOutput("t4_err_sticky", 0, 64'(oErr[0]), 64'd1);

        // Reset mid-transfer of port 1, then ports 0 and 1 contend.
        doReset();
        checkOutput("t5_err_cleared", 0, 64'(oErr[0]), 64'd0);
        blk[1] = 1'b1; req[1] = 1'b1;
        begin
            bit ok;
            waitIssue(ok);
            if (ok) begin
                mrdy = 1'b1;
                @(posedge clk); #1;
                mrdy = 1'b0;
                for (int b = 0; b < 4; b++) begin
                    mval = 1'b1; mrdata = 32'h5500_0000 + 32'(b);
                    @(posedge clk); #1;
                end
                mval = 1'b0;
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req = 3'b011;
        for (int k = 0; k < 2; k++) begin
            checkOutput("t5_rst_busy", k, 64'(oBusy[k]), 64'd0);
            checkOutput("t5_rst_grant", k, 64'(oGrant[k]), 64'd0);
            checkOutput("t5_rst_counts", k, 64'(oGcnt[k]), 64'd0);
        end
        applyStimulus(1, 1'b0, 1'b1);
        req = '0;
        waitCycles(3);
        for (int k = 0; k < 2; k++) begin
            checkOutput("t5_no_done_p1", k, 64'(doneCnt[k][1]), 64'd0);
            order0 = (doneOrder[k].size() > 0) ? doneOrder[k][0] : -1;
            checkOutput("t5_first_grant", k, 64'(order0), 64'd0);
        end
        blk = '0;

        // Port 1 drops its request mid-transfer while port 0 starts requesting.
        doReset();
        blk[1] = 1'b1; req[1] = 1'b1;
        fork
            applyStimulus(16, 1'b0, 1'b1);
            begin
                waitCycles(5);
                req[1] = 1'b0; req[0] = 1'b1;
            end
        join
        applyStimulus(1, 1'b0, 1'b1);
        req = '0;
        waitCycles(3);
        for (int k = 0; k < 2; k++) begin
            checkOutput("t6_txns", k, 64'(doneOrder[k].size()), 64'd2);
            if (doneOrder[k].size() == 2) begin
                checkOutput("t6_first", k, 64'(doneOrder[k][0]), 64'd1);
                checkOutput("t6_second", k, 64'(doneOrder[k][1]), 64'd0);
            end
        end
        checkOutput("t6_beat_err", 0, 64'(oErr[0]), 64'd0);

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-port arbiter between the on-chip requesters (L1I, L1D, L2 or DMA-style masters) and the single external memory system port. Replaces the hard-wired one-requester connection so any cache hierarchy depth can share the DDR3 path. Provides fixed-priority or round-robin selection, per-port handshake demultiplexing, block beat counting, and per-port grant statistics for the peripheral system.

## Interface
- N_PORTS, 3, number of requesters (2..8)
- BW_ADDR, 24, word-address width
- BLOCK_WORDS, 16, beats per block read/write
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (port 0 highest)
- clock_i  in  1  system clock (40 MHz domain)
- reset_i  in  1  synchronous, active-high reset
- req_i  in  N_PORTS  per-port request, held high until that port's done_o
- reqBlock_i  in  N_PORTS  1 = block transfer, 0 = single word
- rw_i  in  N_PORTS  1 = write, 0 = read
- clear_i  in  N_PORTS  clear/flush qualifier, forwarded with request
- add_i  in  N_PORTS*BW_ADDR  packed addresses, port k at [k*BW_ADDR +: BW_ADDR]
- data_i  in  N_PORTS*32  packed write data
- ready_o  out  N_PORTS  write-beat accept / request accept, granted port only
- valid_o  out  N_PORTS  read-beat valid, granted port only
- done_o  out  N_PORTS  one-cycle transaction-complete pulse
- data_o  out  32  read data, shared by all ports
- mem_req_o, mem_reqBlock_o, mem_rw_o, mem_clear_o  out  1  downstream request
- mem_add_o  out  BW_ADDR  downstream address
- mem_data_o  out  32  downstream write data
- mem_ready_i, mem_valid_i, mem_done_i  in  1  downstream handshake
- mem_data_i  in  32  downstream read data
- grant_o  out  3  index of current/last granted port
- busy_o  out  1  high in any state other than IDLE
- beat_err_o  out  1  sticky: completed block had beat count != BLOCK_WORDS
- grant_count_o  out  N_PORTS*32  per-port grant counters, saturating at 0xFFFF_FFFF

## Operation
- States: IDLE, ISSUE, XFER, DONE.
- IDLE: if any req_i set, select winner, latch index into grant_o, latch reqBlock/rw/clear/add of winner, increment its grant counter, go ISSUE. No request: stay.
- Fixed priority: lowest set index. Round-robin: first set index searching from (last_grant+1) mod N_PORTS upward with wrap.
- ISSUE: mem_req_o=1 with latched fields. On mem_ready_i=1: ready_o[g] pulses, beat counter cleared, go XFER. mem_req_o drops the cycle after acceptance.
- XFER read: valid_o[g]=mem_valid_i, data_o=mem_data_i; beat counter +1 per valid beat.
- XFER write: mem_data_o=data_i[g]; ready_o[g]=mem_ready_i; beat counter +1 per ready beat.
- mem_done_i in XFER: go DONE; if reqBlock latched and counter (including any beat in the done cycle) != BLOCK_WORDS, set beat_err_o. Single-word: expected count 1.
- DONE: done_o[g]=1 for exactly one cycle, return IDLE. Next arbitration starts in IDLE the following cycle (one dead cycle between grants).
- Non-granted ports see ready_o/valid_o/done_o = 0 at all times.
- req_i deasserted by granted port mid-transaction: ignored; transaction completes and done_o still pulses.
- Beat counter width clog2(BLOCK_WORDS)+1; saturates at all-ones, never wraps.
- mem_done_i in IDLE/ISSUE: ignored. mem_valid_i outside XFER: ignored.

## Timing
- Reset (reset_i sampled high at edge): state IDLE, every output 0, grant counters 0, beat_err_o 0, round-robin pointer = N_PORTS-1 so port 0 wins first.
- Reset mid-transaction: abort immediately, no done_o pulse; downstream must be reset together.
- Request-to-mem_req_o latency: 1 cycle (req_i seen in IDLE at edge n, mem_req_o high after edge n+1).
- Data path in XFER combinational: valid_o/data_o/mem_data_o/ready_o same cycle as downstream signals.
- mem_done_i at edge m -> done_o[g] high for cycle after m; IDLE next; new grant visible 1 cycle later.
- Simultaneous requests resolved in one cycle; grant_count_o updates on the grant edge.

## Test plan
- Single port 0 block read, BLOCK_WORDS=16: 16 valid beats then done -> valid_o[0] 16 times, done_o[0] one pulse, beat_err_o=0, grant_count[0]=1.
- Ports 0,1,2 requesting continuously, RR_MODE=1, single-word reads -> grant_o sequence 0,1,2,0,1,2; each grant counter = 2 after 6 transactions.
- Same stimulus, RR_MODE=0 -> port 0 granted every time while held; ports 1,2 counters remain 0.
- Block write on port 2 with only 15 ready beats before mem_done_i -> done_o[2] pulses, beat_err_o=1 and stays 1.
- reset_i asserted for one cycle mid-XFER of port 1 -> all outputs 0 next cycle, no done_o[1], next grant goes to port 0 when ports 0 and 1 both request.
- Port 1 drops req_i during XFER while port 0 requests -> port 1 transaction completes with done_o[1], then port 0 granted after one IDLE cycle.
